// File: rtl/matrix_pkg.sv
// Shared parameters, FSM encoding and element ordering for the 2x2 ReLU serializer.
// Latency: none (package only).
// Backpressure: not applicable.
package matrix_pkg;

    localparam int DATA_W_DEF = 128;
    localparam int OUT_W_DEF  = 128;
    localparam int ELEM_CNT   = 4;
    localparam int IDX_W      = 2;
    localparam int NEG_CNT_W  = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    // Beat index -> element position (row*2+col); row-major order c00, c01, c10, c11.
    localparam logic [ELEM_CNT*IDX_W-1:0] ELEM_MAP = {2'd3, 2'd2, 2'd1, 2'd0};

endpackage

// File: rtl/matrix_relu_serializer_relu_sat.sv
// ReLU followed by signed saturation from DATA_W down to OUT_W; flags negative inputs.
// Latency: combinational.
// Backpressure: none.
module relu_sat #(
    parameter int DATA_W = 128,
    parameter int OUT_W  = 128
) (
    input  logic [DATA_W-1:0] dat_i,
    output logic [OUT_W-1:0]  dat_o,
    output logic              is_neg_o
);

    localparam logic [OUT_W-1:0] POS_MAX = {1'b0, {(OUT_W-1){1'b1}}};

    assign is_neg_o = dat_i[DATA_W-1];

    generate
        if (OUT_W == DATA_W) begin : g_relu_only
            // Same width: nothing can overflow, only negatives are clamped.
            always_comb begin
                dat_o = is_neg_o ? '0 : dat_i;
            end
        end else begin : g_relu_sat
            // Any set bit between the sign and the output's sign position means the value exceeds POS_MAX.
            logic ovf;
            assign ovf = |dat_i[DATA_W-2:OUT_W-1];

            // Clamp negatives to zero, overflows to POS_MAX, else keep the low bits.
            always_comb begin
                dat_o = dat_i[OUT_W-1:0];
                if (is_neg_o) begin
                    dat_o = '0;
                end else if (ovf) begin
                    dat_o = POS_MAX;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/matrix_relu_serializer.sv
// Captures a 2x2 result set, applies ReLU/saturation, streams 4 elements row-major.
// Latency: out_valid rises 1 cycle after the capture handshake; one element per accepted beat.
// Backpressure: holds the current element while out_ready is low; new set accepted only when idle or on the last beat.
module matrix_relu_serializer
    import matrix_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OUT_W  = OUT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    c00,
    input  logic [DATA_W-1:0]    c01,
    input  logic [DATA_W-1:0]    c10,
    input  logic [DATA_W-1:0]    c11,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out_data,
    output logic [IDX_W-1:0]     out_idx,
    output logic                 out_last,
    output logic [NEG_CNT_W-1:0] neg_cnt
);

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NEG_CNT_W-1:0]   neg_cnt_q, neg_cnt_d;
    logic [OUT_W-1:0]       elem_q [ELEM_CNT];
    logic [OUT_W-1:0]       elem_d [ELEM_CNT];

    logic [DATA_W-1:0]      c_arr   [ELEM_CNT];
    logic [OUT_W-1:0]       sat_dat [ELEM_CNT];
    logic [ELEM_CNT-1:0]    is_neg;
    logic [NEG_CNT_W-1:0]   neg_pop;
    logic                   capture;
    logic                   beat_done;

    assign c_arr[0] = c00;
    assign c_arr[1] = c01;
    assign c_arr[2] = c10;
    assign c_arr[3] = c11;

    // One activation unit per beat slot, fed from the element that beat carries.
    for (genvar i = 0; i < ELEM_CNT; i++) begin : g_act
        localparam int SRC = int'(ELEM_MAP[i*IDX_W +: IDX_W]);
        relu_sat #(
            .DATA_W (DATA_W),
            .OUT_W  (OUT_W)
        ) u_relu_sat (
            .dat_i    (c_arr[SRC]),
            .dat_o    (sat_dat[i]),
            .is_neg_o (is_neg[i])
        );
    end

    assign out_valid = (state_q == ST_SEND);
    assign out_last  = (idx_q == IDX_W'(ELEM_CNT - 1));
    assign out_idx   = idx_q;
    assign out_data  = elem_q[idx_q];
    assign neg_cnt   = neg_cnt_q;
    assign beat_done = out_valid & out_ready;
    // Held low during reset so no set is accepted before the FSM is released.
    assign in_ready  = rst_n & ((state_q == ST_IDLE) | (beat_done & out_last));
    assign capture   = in_valid & in_ready;

    // Count how many incoming elements the ReLU clamps.
    always_comb begin
        neg_pop = '0;
        for (int i = 0; i < ELEM_CNT; i++) begin
            neg_pop = neg_pop + NEG_CNT_W'(is_neg[i]);
        end
    end

    // Next-state: advance on each accepted beat, reload everything on capture.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        neg_cnt_d = neg_cnt_q;
        for (int i = 0; i < ELEM_CNT; i++) begin
            elem_d[i] = elem_q[i];
        end
        case (state_q)
            ST_IDLE: begin
                if (capture) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (beat_done) begin
                    idx_d = idx_q + IDX_W'(1);
                    if (out_last) begin
                        state_d = capture ? ST_SEND : ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (capture) begin
            idx_d     = '0;
            neg_cnt_d = neg_pop;
            for (int i = 0; i < ELEM_CNT; i++) begin
                elem_d[i] = sat_dat[i];
            end
        end
    end

    // State, index, count and element registers; reset drops any set in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            neg_cnt_q <= '0;
            for (int i = 0; i < ELEM_CNT; i++) begin
                elem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            neg_cnt_q <= neg_cnt_d;
            for (int i = 0; i < ELEM_CNT; i++) begin
                elem_q[i] <= elem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_matrix_relu_serializer.sv
// Directed bench: one full-width instance (pure ReLU) and one 32->16 instance (saturation).
// Latency: inputs driven 1 time unit after posedge, outputs sampled on negedge.
// Backpressure: out_ready toggled by individual scenarios.
module tb_matrix_relu_serializer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] c00, c01, c10, c11;

    logic         in_ready, out_valid, out_last;
    logic [127:0] out_data;
    logic [1:0]   out_idx;
    logic [2:0]   neg_cnt;

    logic         s_in_ready, s_out_valid, s_out_last;
    logic [15:0]  s_out_data;
    logic [1:0]   s_out_idx;
    logic [2:0]   s_neg_cnt;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    matrix_relu_serializer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .c00       (c00),
        .c01       (c01),
        .c10       (c10),
        .c11       (c11),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .neg_cnt   (neg_cnt)
    );

    matrix_relu_serializer #(.DATA_W(32), .OUT_W(16)) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (s_in_ready),
        .c00       (c00[31:0]),
        .c01       (c01[31:0]),
        .c10       (c10[31:0]),
        .c11       (c11[31:0]),
        .out_valid (s_out_valid),
        .out_ready (out_ready),
        .out_data  (s_out_data),
        .out_idx   (s_out_idx),
        .out_last  (s_out_last),
        .neg_cnt   (s_neg_cnt)
    );

    // Present a set for one cycle; callers only use this while the DUT is idle.
    task automatic apply_set(input logic [127:0] a, input logic [127:0] b,
                             input logic [127:0] c, input logic [127:0] d);
        c00 = a; c01 = b; c10 = c; c11 = d;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        c00 = '0; c01 = '0; c10 = '0; c11 = '0;
        #2;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b expected 0", out_valid); else passes++;
        checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %0b expected 0", in_ready); else passes++;
        checks++; if (out_data !== 128'd0) $display("FAIL reset_out_data: got %0h expected 0", out_data); else passes++;
        checks++; if (out_idx !== 2'd0) $display("FAIL reset_out_idx: got %0d expected 0", out_idx); else passes++;
        checks++; if (out_last !== 1'b0) $display("FAIL reset_out_last: got %0b expected 0", out_last); else passes++;
        checks++; if (neg_cnt !== 3'd0) $display("FAIL reset_neg_cnt: got %0d expected 0", neg_cnt); else passes++;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_release_in_ready: got %0b expected 1", in_ready); else passes++;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_release_out_valid: got %0b expected 0", out_valid); else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        logic [127:0] exp [4];
        exp = '{128'd19, 128'd22, 128'd43, 128'd50};
        out_ready = 1'b1;
        c00 = 128'd19; c01 = 128'd22; c10 = 128'd43; c11 = 128'd50;
        in_valid = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) $display("FAIL basic_latency: out_valid got %0b expected 0", out_valid); else passes++;
        checks++; if (in_ready !== 1'b1) $display("FAIL basic_in_ready: got %0b expected 1", in_ready); else passes++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) $display("FAIL basic_valid beat %0d: got %0b expected 1", k, out_valid); else passes++;
            checks++; if (out_data !== exp[k]) $display("FAIL basic_data beat %0d: got %0d expected %0d", k, out_data, exp[k]); else passes++;
            checks++; if (out_idx !== 2'(k)) $display("FAIL basic_idx beat %0d: got %0d expected %0d", k, out_idx, k); else passes++;
            checks++; if (out_last !== (k == 3)) $display("FAIL basic_last beat %0d: got %0b expected %0b", k, out_last, (k == 3)); else passes++;
            checks++; if (neg_cnt !== 3'd0) $display("FAIL basic_neg_cnt beat %0d: got %0d expected 0", k, neg_cnt); else passes++;
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) $display("FAIL basic_idle_valid: got %0b expected 0", out_valid); else passes++;
        checks++; if (in_ready !== 1'b1) $display("FAIL basic_idle_ready: got %0b expected 1", in_ready); else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_relu;
        logic [127:0] exp [4];
        exp = '{128'd7, 128'd0, 128'd7, 128'd0};
        out_ready = 1'b1;
        apply_set(128'd7, -128'sd5, 128'd7, -128'sd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (out_data !== exp[k]) $display("FAIL relu_data beat %0d: got %0h expected %0h", k, out_data, exp[k]); else passes++;
            checks++; if (s_out_data !== exp[k][15:0]) $display("FAIL relu_sat16_data beat %0d: got %0h expected %0h", k, s_out_data, exp[k][15:0]); else passes++;
            checks++; if (neg_cnt !== 3'd2) $display("FAIL relu_neg_cnt beat %0d: got %0d expected 2", k, neg_cnt); else passes++;
            checks++; if (s_neg_cnt !== 3'd2) $display("FAIL relu_sat16_neg_cnt beat %0d: got %0d expected 2", k, s_neg_cnt); else passes++;
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++; if (neg_cnt !== 3'd2) $display("FAIL relu_neg_cnt_hold: got %0d expected 2", neg_cnt); else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_saturation;
        logic [15:0]  exp_s [4];
        logic [127:0] exp_f [4];
        exp_s = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h1234};
        exp_f = '{128'h10000, 128'h8000, 128'h7FFF, 128'h1234};
        out_ready = 1'b1;
        apply_set(128'h10000, 128'h8000, 128'h7FFF, 128'h1234);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (s_out_data !== exp_s[k]) $display("FAIL sat16_data beat %0d: got %0h expected %0h", k, s_out_data, exp_s[k]); else passes++;
            checks++; if (out_data !== exp_f[k]) $display("FAIL sat_full_data beat %0d: got %0h expected %0h", k, out_data, exp_f[k]); else passes++;
            checks++; if (s_neg_cnt !== 3'd0) $display("FAIL sat16_neg_cnt beat %0d: got %0d expected 0", k, s_neg_cnt); else passes++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure;
        logic [127:0] exp [4];
        exp = '{128'd19, 128'd22, 128'd43, 128'd50};
        out_ready = 1'b1;
        apply_set(128'd19, 128'd22, 128'd43, 128'd50);
        @(negedge clk);
        checks++; if (out_data !== 128'd19) $display("FAIL bp_beat0: got %0d expected 19", out_data); else passes++;
        @(posedge clk); #1;
        out_ready = 1'b0;
        c01 = 128'd999;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) $display("FAIL bp_hold_valid cycle %0d: got %0b expected 1", n, out_valid); else passes++;
            checks++; if (out_data !== 128'd22) $display("FAIL bp_hold_data cycle %0d: got %0d expected 22", n, out_data); else passes++;
            checks++; if (out_idx !== 2'd1) $display("FAIL bp_hold_idx cycle %0d: got %0d expected 1", n, out_idx); else passes++;
            checks++; if (in_ready !== 1'b0) $display("FAIL bp_hold_in_ready cycle %0d: got %0b expected 0", n, in_ready); else passes++;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            checks++; if (out_data !== exp[k]) $display("FAIL bp_resume beat %0d: got %0d expected %0d", k, out_data, exp[k]); else passes++;
            checks++; if (out_idx !== 2'(k)) $display("FAIL bp_resume_idx beat %0d: got %0d expected %0d", k, out_idx, k); else passes++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back;
        logic [127:0] exp [8];
        exp = '{128'd19, 128'd22, 128'd43, 128'd50, 128'd7, 128'd0, 128'd7, 128'd0};
        out_ready = 1'b1;
        c00 = 128'd19; c01 = 128'd22; c10 = 128'd43; c11 = 128'd50;
        in_valid = 1'b1;
        @(posedge clk); #1;
        c00 = 128'd7; c01 = -128'sd5; c10 = 128'd7; c11 = -128'sd1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) $display("FAIL b2b_valid beat %0d: got %0b expected 1", k, out_valid); else passes++;
            checks++; if (out_data !== exp[k]) $display("FAIL b2b_data beat %0d: got %0d expected %0d", k, out_data, exp[k]); else passes++;
            checks++; if (out_idx !== 2'(k % 4)) $display("FAIL b2b_idx beat %0d: got %0d expected %0d", k, out_idx, k % 4); else passes++;
            if (k == 3) begin
                checks++; if (in_ready !== 1'b1) $display("FAIL b2b_last_in_ready: got %0b expected 1", in_ready); else passes++;
            end
            if (k == 4) begin
                checks++; if (neg_cnt !== 3'd2) $display("FAIL b2b_neg_cnt: got %0d expected 2", neg_cnt); else passes++;
            end
            @(posedge clk); #1;
            if (k == 3) in_valid = 1'b0;
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) $display("FAIL b2b_end_valid: got %0b expected 0", out_valid); else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midstream;
        out_ready = 1'b1;
        apply_set(128'd7, -128'sd5, 128'd7, -128'sd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (out_idx !== 2'd2) $display("FAIL midrst_pre_idx: got %0d expected 2", out_idx); else passes++;
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %0b expected 0", out_valid); else passes++;
        checks++; if (neg_cnt !== 3'd0) $display("FAIL midrst_neg_cnt: got %0d expected 0", neg_cnt); else passes++;
        checks++; if (in_ready !== 1'b0) $display("FAIL midrst_in_ready: got %0b expected 0", in_ready); else passes++;
        checks++; if (out_idx !== 2'd0) $display("FAIL midrst_out_idx: got %0d expected 0", out_idx); else passes++;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) $display("FAIL midrst_stale_valid cycle %0d: got %0b expected 0", n, out_valid); else passes++;
            checks++; if (in_ready !== 1'b1) $display("FAIL midrst_ready cycle %0d: got %0b expected 1", n, in_ready); else passes++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_relu();
        test_saturation();
        test_backpressure();
        test_back_to_back();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d passed %0d", checks, passes);
        $fatal(1);
    end

endmodule
